mesh_route_unit: RTL and testbench

- Parametrised, registered route-computation stage for one NoC router on an arbitrary MESH_X x MESH_Y mesh. Generalises the fixed 2x2 combinational table.
- Serves NUM_PORTS input channels in parallel. Each channel runs its own valid/ready handshake and one pipeline register.
- Routing is dimension-ordered, XY or YX, selected per packet.
- Head flits compute the route. Body and tail flits reuse the route locked for their packet.
- Sits between the input buffers and the switch allocator.

---
 rtl/mesh_route_unit_pkg.sv | 17 +
 rtl/mesh_route_unit_route_xy_calc.sv | 37 +++
 rtl/mesh_route_unit.sv | 114 +++++++++++
 tb/tb_mesh_route_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_route_unit_pkg.sv
// Shared direction codes and per-channel FSM states for the mesh route unit.
package mesh_route_unit_pkg;

  localparam int BITS_DIR = 3;

  localparam logic [BITS_DIR-1:0] DIR_LOCAL = 3'd0;
  localparam logic [BITS_DIR-1:0] DIR_NORTH = 3'd1;
  localparam logic [BITS_DIR-1:0] DIR_EAST  = 3'd2;
  localparam logic [BITS_DIR-1:0] DIR_SOUTH = 3'd3;
  localparam logic [BITS_DIR-1:0] DIR_WEST  = 3'd4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/mesh_route_unit_route_xy_calc.sv
// Combinational dimension-ordered route: XY (x first) or YX (y first).
// Row-major addressing: x = addr % MESH_X, y = addr / MESH_X.
module route_xy_calc
  import mesh_route_unit_pkg::*;
#(
  parameter int MESH_X  = 4,
  parameter int ADDR_SZ = 4
) (
  input  logic [ADDR_SZ-1:0]  dest,
  input  logic [ADDR_SZ-1:0]  local_id,
  input  logic                yx,
  output logic [BITS_DIR-1:0] dir
);

  int dest_x, dest_y, loc_x, loc_y;

  assign dest_x = int'(dest) % MESH_X;
  assign dest_y = int'(dest) / MESH_X;
  assign loc_x  = int'(local_id) % MESH_X;
  assign loc_y  = int'(local_id) / MESH_X;

  always_comb begin
    dir = DIR_LOCAL;
    if (yx) begin
      if (dest_y > loc_y)      dir = DIR_SOUTH;
      else if (dest_y < loc_y) dir = DIR_NORTH;
      else if (dest_x > loc_x) dir = DIR_EAST;
      else if (dest_x < loc_x) dir = DIR_WEST;
    end else begin
      if (dest_x > loc_x)      dir = DIR_EAST;
      else if (dest_x < loc_x) dir = DIR_WEST;
      else if (dest_y > loc_y) dir = DIR_SOUTH;
      else if (dest_y < loc_y) dir = DIR_NORTH;
    end
  end

endmodule

// File: rtl/mesh_route_unit.sv
// Registered route stage: per-channel valid/ready pipeline register plus a
// head/locked FSM so body and tail flits follow the route chosen by their head.
module mesh_route_unit
  import mesh_route_unit_pkg::*;
#(
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int NUM_PORTS = 5,
  parameter int ROUTER_ID = 0,
  parameter int ADDR_SZ   = $clog2(MESH_X * MESH_Y)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_yx,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_head,
  input  logic [NUM_PORTS-1:0]          in_tail,
  input  logic [NUM_PORTS*ADDR_SZ-1:0]  in_dest,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*BITS_DIR-1:0] out_dir,
  output logic [NUM_PORTS-1:0]          out_tail,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          err
);

  localparam int NUM_NODES = MESH_X * MESH_Y;
  localparam logic [ADDR_SZ-1:0] LOCAL_ID = ADDR_SZ'(ROUTER_ID);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
      state_e              state_q, state_d;
      logic [BITS_DIR-1:0] lock_dir_q, lock_dir_d;
      logic [BITS_DIR-1:0] out_dir_q, out_dir_d;
      logic                out_valid_q, out_valid_d;
      logic                out_tail_q, out_tail_d;
      logic                err_q, err_d;
      logic [ADDR_SZ-1:0]  dest;
      logic [BITS_DIR-1:0] calc_dir, route_dir;
      logic                bad_dest, xfer;

      assign dest = in_dest[gi*ADDR_SZ +: ADDR_SZ];

      route_xy_calc #(
        .MESH_X  (MESH_X),
        .ADDR_SZ (ADDR_SZ)
      ) u_calc (
        .dest     (dest),
        .local_id (LOCAL_ID),
        .yx       (cfg_yx),
        .dir      (calc_dir)
      );

      // Non-power-of-two meshes leave address codes with no node behind them.
      assign bad_dest  = int'(dest) >= NUM_NODES;
      assign route_dir = bad_dest ? DIR_LOCAL : calc_dir;

      assign in_ready[gi] = !out_valid_q || out_ready[gi];
      assign xfer         = in_valid[gi] && in_ready[gi];

      always_comb begin
        state_d     = state_q;
        lock_dir_d  = lock_dir_q;
        out_dir_d   = out_dir_q;
        out_tail_d  = out_tail_q;
        err_d       = err_q;
        out_valid_d = out_valid_q && !out_ready[gi];
        if (xfer) begin
          if (in_head[gi]) begin
            // A head while LOCKED breaks protocol but still starts a new packet.
            err_d       = err_q || bad_dest || (state_q == S_LOCKED);
            out_valid_d = 1'b1;
            out_dir_d   = route_dir;
            out_tail_d  = in_tail[gi];
            lock_dir_d  = route_dir;
            state_d     = in_tail[gi] ? S_IDLE : S_LOCKED;
          end else if (state_q == S_IDLE) begin
            err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_dir_d   = lock_dir_q;
            out_tail_d  = in_tail[gi];
            if (in_tail[gi]) state_d = S_IDLE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q     <= S_IDLE;
          lock_dir_q  <= DIR_LOCAL;
          out_dir_q   <= DIR_LOCAL;
          out_valid_q <= 1'b0;
          out_tail_q  <= 1'b0;
          err_q       <= 1'b0;
        end else begin
          state_q     <= state_d;
          lock_dir_q  <= lock_dir_d;
          out_dir_q   <= out_dir_d;
          out_valid_q <= out_valid_d;
          out_tail_q  <= out_tail_d;
          err_q       <= err_d;
        end
      end

      assign out_valid[gi]                    = out_valid_q;
      assign out_dir[gi*BITS_DIR +: BITS_DIR] = out_dir_q;
      assign out_tail[gi]                     = out_tail_q;
      assign err[gi]                          = err_q;
    end
  endgenerate

endmodule

// File: tb/tb_mesh_route_unit.sv
// Bench for mesh_route_unit on a 4x4 mesh at router 5 (x=1, y=1), plus a 4x5
// instance for out-of-range destinations; routed flits go through a scoreboard.
module tb_mesh_route_unit;
  import mesh_route_unit_pkg::*;

  localparam int NP = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_yx;
  logic [NP-1:0]   in_valid, in_head, in_tail, in_ready;
  logic [NP*4-1:0] in_dest;
  logic [NP-1:0]   out_valid, out_tail, out_ready, err;
  logic [NP*3-1:0] out_dir;

  logic [NP-1:0]   d2_valid, d2_head, d2_tail, d2_in_ready;
  logic [NP*5-1:0] d2_dest;
  logic [NP-1:0]   d2_out_valid, d2_out_tail, d2_out_ready, d2_err;
  logic [NP*3-1:0] d2_out_dir;

  int errors = 0;
  int checks = 0;

  logic [2:0] drv_dir [NP];
  logic       drv_drop [NP];
  logic [3:0] sb_q [NP][$];

  always #5 clk = ~clk;

  mesh_route_unit #(.MESH_X(4), .MESH_Y(4), .NUM_PORTS(NP), .ROUTER_ID(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_yx(cfg_yx),
    .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail), .in_dest(in_dest),
    .in_ready(in_ready), .out_valid(out_valid), .out_dir(out_dir),
    .out_tail(out_tail), .out_ready(out_ready), .err(err)
  );

  mesh_route_unit #(.MESH_X(4), .MESH_Y(5), .NUM_PORTS(NP), .ROUTER_ID(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_yx(cfg_yx),
    .in_valid(d2_valid), .in_head(d2_head), .in_tail(d2_tail), .in_dest(d2_dest),
    .in_ready(d2_in_ready), .out_valid(d2_out_valid), .out_dir(d2_out_dir),
    .out_tail(d2_out_tail), .out_ready(d2_out_ready), .err(d2_err)
  );

  // Scoreboard: pop on downstream acceptance, push on upstream transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NP; ch++) sb_q[ch].delete();
    end else begin
      for (int ch = 0; ch < NP; ch++) begin
        if (out_valid[ch] && out_ready[ch]) begin
          checks++;
          if (sb_q[ch].size() == 0) begin
            errors++;
            $display("FAIL sb_spurious ch%0d: got flit dir=%0d tail=%0d, required none",
                     ch, out_dir[ch*3 +: 3], out_tail[ch]);
          end else begin
            logic [3:0] exp;
            exp = sb_q[ch].pop_front();
            if ({out_tail[ch], out_dir[ch*3 +: 3]} !== exp) begin
              errors++;
              $display("FAIL sb_flit ch%0d: got dir=%0d tail=%0d, required dir=%0d tail=%0d",
                       ch, out_dir[ch*3 +: 3], out_tail[ch], exp[2:0], exp[3]);
            end else begin
              $display("flit ch%0d dir=%0d tail=%0d", ch, exp[2:0], exp[3]);
            end
          end
        end
        if (in_valid[ch] && in_ready[ch] && !drv_drop[ch])
          sb_q[ch].push_back({in_tail[ch], drv_dir[ch]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic h, input logic t, input int dest,
                       input logic [2:0] dir, input logic drop);
    in_valid[ch]       = 1'b1;
    in_head[ch]        = h;
    in_tail[ch]        = t;
    in_dest[ch*4 +: 4] = 4'(dest);
    drv_dir[ch]        = dir;
    drv_drop[ch]       = drop;
  endtask

  task automatic idle(input int ch);
    in_valid[ch] = 1'b0;
    in_head[ch]  = 1'b0;
    in_tail[ch]  = 1'b0;
    drv_drop[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 5'h00) begin errors++; $display("FAIL rst_out_valid: got %b need %b", out_valid, 5'h00); end
    checks++; if (out_dir !== 15'h0) begin errors++; $display("FAIL rst_out_dir: got %h need %h", out_dir, 15'h0); end
    checks++; if (out_tail !== 5'h00) begin errors++; $display("FAIL rst_out_tail: got %b need %b", out_tail, 5'h00); end
    checks++; if (err !== 5'h00) begin errors++; $display("FAIL rst_err: got %b need %b", err, 5'h00); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 5'h1f) begin errors++; $display("FAIL rst_in_ready: got %b need %b", in_ready, 5'h1f); end
  endtask

  task automatic test_xy_ch0();
    int         dests [5] = '{7, 4, 13, 1, 5};
    logic [2:0] dirs  [5] = '{DIR_EAST, DIR_WEST, DIR_SOUTH, DIR_NORTH, DIR_LOCAL};
    cfg_yx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b1, dests[k], dirs[k], 1'b0);
      step();
      checks++;
      if (out_valid[0] !== 1'b1 || out_dir[2:0] !== dirs[k]) begin
        errors++;
        $display("FAIL xy_latency k%0d: got valid=%b dir=%0d, required valid=1 dir=%0d",
                 k, out_valid[0], out_dir[2:0], dirs[k]);
      end
    end
    idle(0);
    step();
    step();
  endtask

  task automatic test_cfg_ch1();
    cfg_yx = 1'b0; drive(1, 1'b1, 1'b1, 15, DIR_EAST, 1'b0);  step();
    cfg_yx = 1'b1; drive(1, 1'b1, 1'b1, 15, DIR_SOUTH, 1'b0); step();
    cfg_yx = 1'b0; drive(1, 1'b1, 1'b0, 15, DIR_EAST, 1'b0);  step();
    cfg_yx = 1'b1; drive(1, 1'b0, 1'b0, 0, DIR_EAST, 1'b0);   step();
    cfg_yx = 1'b0; drive(1, 1'b0, 1'b0, 0, DIR_EAST, 1'b0);   step();
    cfg_yx = 1'b1; drive(1, 1'b0, 1'b1, 0, DIR_EAST, 1'b0);   step();
    cfg_yx = 1'b0; idle(1);
    step();
    step();
  endtask

  task automatic test_stall_ch2();
    drive(2, 1'b1, 1'b0, 0, DIR_WEST, 1'b0);
    step();
    drive(2, 1'b0, 1'b0, 0, DIR_WEST, 1'b0);
    out_ready[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1 || out_dir[8:6] !== DIR_WEST || out_tail[2] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d: got rdy=%b vld=%b dir=%0d tail=%b, required rdy=0 vld=1 dir=%0d tail=0",
                 k, in_ready[2], out_valid[2], out_dir[8:6], out_tail[2], DIR_WEST);
      end
    end
    out_ready[2] = 1'b1;
    step();
    drive(2, 1'b0, 1'b0, 0, DIR_WEST, 1'b0);
    step();
    drive(2, 1'b0, 1'b1, 0, DIR_WEST, 1'b0);
    step();
    idle(2);
    step();
    step();
  endtask

  task automatic test_err_ch3();
    drive(3, 1'b0, 1'b0, 0, DIR_LOCAL, 1'b1);
    drive(4, 1'b1, 1'b1, 6, DIR_EAST, 1'b0);
    d2_valid[3] = 1'b1; d2_head[3] = 1'b1; d2_tail[3] = 1'b1; d2_dest[15 +: 5] = 5'd20;
    d2_valid[2] = 1'b1; d2_head[2] = 1'b1; d2_tail[2] = 1'b1; d2_dest[10 +: 5] = 5'd16;
    step();
    idle(3); idle(4);
    d2_valid = '0;
    checks++; if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL drop_no_out: got %b need 0", out_valid[3]); end
    checks++; if (err !== 5'b01000) begin errors++; $display("FAIL drop_err: got %b need %b", err, 5'b01000); end
    checks++;
    if (d2_out_valid[3] !== 1'b1 || d2_out_dir[11:9] !== DIR_LOCAL || d2_err[3] !== 1'b1) begin
      errors++;
      $display("FAIL range_err: got vld=%b dir=%0d err=%b, required vld=1 dir=%0d err=1",
               d2_out_valid[3], d2_out_dir[11:9], d2_err[3], DIR_LOCAL);
    end
    checks++;
    if (d2_out_valid[2] !== 1'b1 || d2_out_dir[8:6] !== DIR_WEST || d2_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL range_ok: got vld=%b dir=%0d err=%b, required vld=1 dir=%0d err=0",
               d2_out_valid[2], d2_out_dir[8:6], d2_err[2], DIR_WEST);
    end
    step();
  endtask

  task automatic test_all_parallel();
    int         dests [5] = '{7, 4, 13, 1, 5};
    logic [2:0] dirs  [5] = '{DIR_EAST, DIR_WEST, DIR_SOUTH, DIR_NORTH, DIR_LOCAL};
    logic [14:0] exp_dir;
    cfg_yx = 1'b0;
    for (int ch = 0; ch < NP; ch++) begin
      drive(ch, 1'b1, 1'b1, dests[4-ch], dirs[4-ch], 1'b0);
      exp_dir[ch*3 +: 3] = dirs[4-ch];
    end
    step();
    for (int ch = 0; ch < NP; ch++) idle(ch);
    checks++;
    if (out_valid !== 5'h1f || out_dir !== exp_dir) begin
      errors++;
      $display("FAIL parallel: got vld=%b dir=%h, required vld=%b dir=%h", out_valid, out_dir, 5'h1f, exp_dir);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    drive(2, 1'b1, 1'b0, 0, DIR_WEST, 1'b0);
    step();
    idle(2);
    out_ready[2] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 5'h00) begin errors++; $display("FAIL rstmid_valid: got %b need %b", out_valid, 5'h00); end
    checks++; if (err !== 5'h00) begin errors++; $display("FAIL rstmid_err: got %b need %b", err, 5'h00); end
    out_ready[2] = 1'b1;
    drive(2, 1'b0, 1'b0, 0, DIR_LOCAL, 1'b1);
    step();
    idle(2);
    step();
    checks++; if (err !== 5'b00100) begin errors++; $display("FAIL rstmid_drop_err: got %b need %b", err, 5'b00100); end
    checks++; if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL rstmid_drop_out: got %b need 0", out_valid[2]); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_yx = 1'b0;
    in_valid = '0; in_head = '0; in_tail = '0; in_dest = '0; out_ready = '1;
    d2_valid = '0; d2_head = '0; d2_tail = '0; d2_dest = '0; d2_out_ready = '1;
    for (int ch = 0; ch < NP; ch++) begin drv_dir[ch] = DIR_LOCAL; drv_drop[ch] = 1'b0; end

    test_reset();
    test_xy_ch0();
    test_cfg_ch1();
    test_stall_ch2();
    test_err_ch3();
    test_all_parallel();
    test_reset_mid();
    step();
    for (int ch = 0; ch < NP; ch++) begin
      checks++;
      if (sb_q[ch].size() != 0) begin
        errors++;
        $display("FAIL sb_lost ch%0d: got %0d flits outstanding, required 0", ch, sb_q[ch].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
